// File: rtl/dlsc_dma_buffer.sv
// First-word-fall-through data buffer between the DMA read and write engines.
// Optional high-water-mark statistic built only when DLSC_DMA_BUFFER_HWM_EN is defined.
module dlsc_dma_buffer #(
  parameter int DATA = 32,
  parameter int BUFA = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fifo_wr_push,
  input  logic [DATA-1:0]   fifo_wr_data,
  output logic              fifo_wr_full,
  output logic [BUFA:0]     fifo_wr_free,
  output logic              fifo_wr_overflow,
  input  logic              fifo_rd_pop,
  output logic [DATA-1:0]   fifo_rd_data,
  output logic [BUFA:0]     fifo_rd_count,
  output logic              fifo_rd_empty,
  output logic              fifo_rd_underflow,
  output logic [BUFA:0]     stat_hwm
);

  localparam logic [BUFA:0] DEPTH_C = {1'b1, {BUFA{1'b0}}};
  localparam logic [BUFA:0] ONE_C   = {{BUFA{1'b0}}, 1'b1};
  localparam logic [BUFA:0] ZERO_C  = {(BUFA+1){1'b0}};

  logic [DATA-1:0] mem_r [0:(1<<BUFA)-1];
  logic [DATA-1:0] out_data_r;
  logic            out_valid_r;
  logic [BUFA:0]   wr_ptr_r;
  logic [BUFA:0]   rd_ptr_r;
  logic [BUFA:0]   count_r;
  logic [BUFA:0]   free_r;
  logic            full_r;
  logic            overflow_r;
  logic            underflow_r;

  logic            clr_s;
  logic            push_acc_s;
  logic            pop_acc_s;
  logic            load_s;
  logic [BUFA:0]   wr_ptr_nxt_s;
  logic [BUFA:0]   rd_addr_s;
  logic [BUFA:0]   occ_nxt_s;

  // rd_ptr_r indexes the head word; its RAM slot stays allocated until popped,
  // so capacity is exactly 2**BUFA including the output register.
  // Next-state pointer arithmetic and accept decisions
  always_comb begin
    clr_s      = rst | flush;
    push_acc_s = fifo_wr_push & ~full_r & ~clr_s;
    pop_acc_s  = fifo_rd_pop & out_valid_r & ~clr_s;
    load_s     = pop_acc_s | ~out_valid_r;
    if (push_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + ONE_C;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (pop_acc_s) begin
      rd_addr_s = rd_ptr_r + ONE_C;
    end else begin
      rd_addr_s = rd_ptr_r;
    end
    occ_nxt_s = wr_ptr_nxt_s - rd_addr_s;
  end

  // Storage write port and prefetching read port feeding the output register
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      mem_r[wr_ptr_r[BUFA-1:0]] <= fifo_wr_data;
    end
    if (load_s) begin
      out_data_r <= mem_r[rd_addr_s[BUFA-1:0]];
    end
  end

  // Pointers, registered status outputs and sticky error flags.
  // Using the pre-edge write pointer excludes a word pushed at this edge
  // from the committed count and from the output-register load.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      wr_ptr_r    <= ZERO_C;
      rd_ptr_r    <= ZERO_C;
      out_valid_r <= 1'b0;
      count_r     <= ZERO_C;
      free_r      <= DEPTH_C;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_addr_s;
      out_valid_r <= (wr_ptr_r != rd_addr_s);
      count_r     <= wr_ptr_r - rd_addr_s;
      free_r      <= DEPTH_C - occ_nxt_s;
      full_r      <= (occ_nxt_s == DEPTH_C);
      overflow_r  <= overflow_r | (fifo_wr_push & full_r);
      underflow_r <= underflow_r | (fifo_rd_pop & ~out_valid_r);
    end
  end

`ifdef DLSC_DMA_BUFFER_HWM_EN
  logic [BUFA:0] hwm_r;

  // Occupancy high-water mark since the last clear
  always_ff @(posedge clk) begin
    if (clr_s) begin
      hwm_r <= ZERO_C;
    end else if (occ_nxt_s > hwm_r) begin
      hwm_r <= occ_nxt_s;
    end else begin
      hwm_r <= hwm_r;
    end
  end

  assign stat_hwm = hwm_r;
`else
  assign stat_hwm = ZERO_C;
`endif

  assign fifo_wr_full      = full_r;
  assign fifo_wr_free      = free_r;
  assign fifo_wr_overflow  = overflow_r;
  assign fifo_rd_data      = out_data_r;
  assign fifo_rd_count     = count_r;
  assign fifo_rd_empty     = ~out_valid_r;
  assign fifo_rd_underflow = underflow_r;

endmodule

// File: tb/tb_dlsc_dma_buffer.sv
// Self-checking bench for dlsc_dma_buffer: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_dlsc_dma_buffer;
  localparam int DATA  = 32;
  localparam int BUFA  = 9;
  localparam int DEPTH = 512;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            fifo_wr_push = 1'b0;
  logic [DATA-1:0] fifo_wr_data = '0;
  logic            fifo_wr_full;
  logic [BUFA:0]   fifo_wr_free;
  logic            fifo_wr_overflow;
  logic            fifo_rd_pop = 1'b0;
  logic [DATA-1:0] fifo_rd_data;
  logic [BUFA:0]   fifo_rd_count;
  logic            fifo_rd_empty;
  logic            fifo_rd_underflow;
  logic [BUFA:0]   stat_hwm;

  always #5 clk = ~clk;

  dlsc_dma_buffer #(.DATA(DATA), .BUFA(BUFA)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fifo_wr_push(fifo_wr_push), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full), .fifo_wr_free(fifo_wr_free),
    .fifo_wr_overflow(fifo_wr_overflow),
    .fifo_rd_pop(fifo_rd_pop), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_count(fifo_rd_count), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_underflow(fifo_rd_underflow), .stat_hwm(stat_hwm)
  );

  // Reference model: each entry remembers the edge number at which it was pushed;
  // an entry is poppable once a later edge has passed.
  typedef struct { logic [DATA-1:0] data; int tag; } ent_t;
  ent_t q[$];
  int   edge_n = 0;
  bit   m_ovf = 1'b0;
  bit   m_udf = 1'b0;
  int   m_hwm = 0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit push; bit pop; bit flsh; logic [DATA-1:0] data;
    int e_count; int e_free; bit e_empty; bit e_udf; logic [DATA-1:0] e_data;
  } vec_t;
  vec_t vt[7];

  function automatic int visible();
    int v = 0;
    foreach (q[i]) if (q[i].tag < edge_n) v++;
    return v;
  endfunction

  function automatic int exp_hwm();
`ifdef DLSC_DMA_BUFFER_HWM_EN
    return m_hwm;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit p, input bit o, input bit clr, input logic [DATA-1:0] d);
    int vis_pre, sz_pre;
    if (clr) begin
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_hwm = 0;
      edge_n++;
    end else begin
      vis_pre = visible();
      sz_pre  = q.size();
      edge_n++;
      if (o) begin
        if (vis_pre > 0) void'(q.pop_front());
        else m_udf = 1'b1;
      end
      if (p) begin
        if (sz_pre < DEPTH) q.push_back('{d, edge_n});
        else m_ovf = 1'b1;
      end
      if (q.size() > m_hwm) m_hwm = q.size();
    end
  endtask

  task automatic check_model();
    int vis;
    vis = visible();
    chk("m_count", fifo_rd_count, vis);
    chk("m_empty", fifo_rd_empty, (vis == 0));
    chk("m_free", fifo_wr_free, DEPTH - q.size());
    chk("m_full", fifo_wr_full, (q.size() == DEPTH));
    chk("m_ovf", fifo_wr_overflow, m_ovf);
    chk("m_udf", fifo_rd_underflow, m_udf);
    chk("m_hwm", stat_hwm, exp_hwm());
    if (vis > 0) chk("m_data", fifo_rd_data, q[0].data);
  endtask

  // One clock: drive inputs, advance model at the edge, sample 2 time units later.
  task automatic step(input bit p, input bit o, input bit f, input bit r, input logic [DATA-1:0] d);
    fifo_wr_push = p; fifo_rd_pop = o; flush = f; rst = r; fifo_wr_data = d;
    @(posedge clk);
    model_edge(p, o, f | r, d);
    #1;
    fifo_wr_push = 1'b0; fifo_rd_pop = 1'b0; flush = 1'b0; rst = 1'b0;
    #1;
    check_model();
  endtask

  initial begin
    int n;
    logic [DATA-1:0] w;
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'hA5A5A5A5, 0, 511, 1'b1, 1'b0, 32'h0};
    vt[1] = '{1'b0, 1'b0, 1'b0, 32'h0,        1, 511, 1'b0, 1'b0, 32'hA5A5A5A5};
    vt[2] = '{1'b1, 1'b0, 1'b0, 32'h11111111, 1, 510, 1'b0, 1'b0, 32'hA5A5A5A5};
    vt[3] = '{1'b0, 1'b1, 1'b0, 32'h0,        1, 511, 1'b0, 1'b0, 32'h11111111};
    vt[4] = '{1'b0, 1'b1, 1'b0, 32'h0,        0, 512, 1'b1, 1'b0, 32'h0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0,        0, 512, 1'b1, 1'b1, 32'h0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 32'h0,        0, 512, 1'b1, 1'b0, 32'h0};

    #2;
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("rst_full", fifo_wr_full, 1'b0);
    chk("rst_free", fifo_wr_free, 512);
    chk("rst_ovf", fifo_wr_overflow, 1'b0);
    chk("rst_empty", fifo_rd_empty, 1'b1);
    chk("rst_count", fifo_rd_count, 0);
    chk("rst_udf", fifo_rd_underflow, 1'b0);
    chk("rst_hwm", stat_hwm, 0);

    // Directed table: single push latency, push/pop, underflow, flush clear
    for (int i = 0; i < 7; i++) begin
      step(vt[i].push, vt[i].pop, vt[i].flsh, 1'b0, vt[i].data);
      chk($sformatf("vec%0d_count", i), fifo_rd_count, vt[i].e_count);
      chk($sformatf("vec%0d_free", i), fifo_wr_free, vt[i].e_free);
      chk($sformatf("vec%0d_empty", i), fifo_rd_empty, vt[i].e_empty);
      chk($sformatf("vec%0d_udf", i), fifo_rd_underflow, vt[i].e_udf);
      if (!vt[i].e_empty) chk($sformatf("vec%0d_data", i), fifo_rd_data, vt[i].e_data);
    end

    // 16 pushes, 2 idle cycles, 16 back-to-back pops
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1000 + i);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("burst_count0", fifo_rd_count, 16);
    for (int k = 1; k <= 16; k++) begin
      w = 32'h1000 + k - 1;
      chk("burst_data", fifo_rd_data, w);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("burst_count", fifo_rd_count, 16 - k);
    end
    chk("burst_free", fifo_wr_free, 512);

    // Fill to full, overflow, push+pop at full, then drain
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    chk("fill_full", fifo_wr_full, 1'b1);
    chk("fill_free", fifo_wr_free, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    chk("fill_ovf", fifo_wr_overflow, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
    chk("pp_free", fifo_wr_free, 1);
    chk("pp_ovf", fifo_wr_overflow, 1'b1);
    chk("pp_full", fifo_wr_full, 1'b0);
    n = 0;
    while (!fifo_rd_empty && n < 600) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    chk("drain_n", n, 511);
    chk("drain_free", fifo_wr_free, 512);

    // High-water mark: push 300, pop 300, push 10
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef DLSC_DMA_BUFFER_HWM_EN
    chk("hwm", stat_hwm, 300);
`else
    chk("hwm", stat_hwm, 0);
`endif

    // Randomized traffic with biased phases and occasional flush/reset
    for (int ph = 0; ph < 4; ph++) begin
      int pp, op;
      pp = (ph == 1) ? 90 : (ph == 2) ? 20 : 55;
      op = (ph == 1) ? 20 : (ph == 2) ? 90 : 50;
      for (int i = 0; i < 800; i++) begin
        step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < op,
             $urandom_range(0, 399) == 0, $urandom_range(0, 799) == 0, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
